// File: rtl/irq_dispatch_seq.sv
// SM83 interrupt entry sequencer: HALT wake-up plus the five M-cycle dispatch
// (PC rewind, SP decrement, PCH push, PCL push, vector jump) over the regfile rr ports.
module irq_dispatch_seq #(
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 32'd8,
    parameter int          NUM_IRQ    = 32'd5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_tick,
    input  logic [NUM_IRQ-1:0] ie_flags,
    input  logic [NUM_IRQ-1:0] if_flags,
    input  logic               ime,
    input  logic               halted,
    input  logic               instr_bound,
    input  logic [15:0]        rr_rdata,
    output logic               read_rr,
    output logic [2:0]         read_reg_rr,
    output logic               write_rr,
    output logic [2:0]         write_reg_rr,
    output logic [15:0]        data_in_rr,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    output logic [NUM_IRQ-1:0] if_clr,
    output logic               ime_clr,
    output logic               halt_exit,
    output logic               busy
);

    localparam logic [2:0] SEL_SP = 3'd3;
    localparam logic [2:0] SEL_PC = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_M5   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [15:0]        pc_r;
    logic [15:0]        sp_r;
    logic [15:0]        vec_r;
    logic [NUM_IRQ-1:0] pend_s;
    logic               any_pend_s;

    // Lowest set bit wins; returns a one-hot mask (all zero when nothing pends).
    function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] p);
        logic [NUM_IRQ-1:0] oh;
        oh = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (p[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Vector address of the winning source, or 0000 when the latch found nothing.
    function automatic logic [15:0] vector_of(input logic [NUM_IRQ-1:0] p);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (p[i]) begin
                v = VEC_BASE + 16'(i * VEC_STRIDE);
            end
        end
        return v;
    endfunction

    assign pend_s     = ie_flags & if_flags;
    assign any_pend_s = |pend_s;
    assign busy       = (state_r != S_IDLE);

    // State register and the values carried between M-cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pc_r    <= 16'h0000;
            sp_r    <= 16'h0000;
            vec_r   <= 16'h0000;
        end else begin
            state_r <= state_s;
            if (m_tick && state_r == S_M1) begin
                pc_r <= rr_rdata - 16'd1;
            end
            if (m_tick && state_r == S_M3) begin
                sp_r <= rr_rdata - 16'd1;
            end
            if (m_tick && state_r == S_M4) begin
                vec_r <= vector_of(pend_s);
            end
        end
    end

    // Next state and strobes; strobes fire only on the m_tick clk of each M-cycle.
    always_comb begin
        state_s      = state_r;
        read_rr      = 1'b0;
        read_reg_rr  = SEL_PC;
        write_rr     = 1'b0;
        write_reg_rr = SEL_PC;
        data_in_rr   = 16'h0000;
        mem_addr     = 16'h0000;
        mem_wdata    = 8'h00;
        mem_we       = 1'b0;
        if_clr       = '0;
        ime_clr      = 1'b0;
        halt_exit    = 1'b0;
        if (rst) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    halt_exit = m_tick & halted & any_pend_s;
                    if (m_tick && ime && any_pend_s && (instr_bound || halted)) begin
                        state_s = S_M1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_M1: begin
                    data_in_rr = rr_rdata - 16'd1;
                    read_rr    = m_tick;
                    write_rr   = m_tick;
                    state_s    = m_tick ? S_M2 : S_M1;
                end
                S_M2: begin
                    read_reg_rr  = SEL_SP;
                    write_reg_rr = SEL_SP;
                    data_in_rr   = rr_rdata - 16'd1;
                    read_rr      = m_tick;
                    write_rr     = m_tick;
                    state_s      = m_tick ? S_M3 : S_M2;
                end
                S_M3: begin
                    read_reg_rr  = SEL_SP;
                    write_reg_rr = SEL_SP;
                    data_in_rr   = rr_rdata - 16'd1;
                    mem_addr     = rr_rdata;
                    mem_wdata    = pc_r[15:8];
                    read_rr      = m_tick;
                    write_rr     = m_tick;
                    mem_we       = m_tick;
                    state_s      = m_tick ? S_M4 : S_M3;
                end
                S_M4: begin
                    // Pending set is sampled here so IE/IF changes during the PCH push count.
                    read_reg_rr  = SEL_SP;
                    write_reg_rr = SEL_SP;
                    mem_addr     = sp_r;
                    mem_wdata    = pc_r[7:0];
                    mem_we       = m_tick;
                    ime_clr      = m_tick;
                    if_clr       = m_tick ? lowest_onehot(pend_s) : '0;
                    state_s      = m_tick ? S_M5 : S_M4;
                end
                S_M5: begin
                    data_in_rr = vec_r;
                    write_rr   = m_tick;
                    state_s    = m_tick ? S_IDLE : S_M5;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Randomised scoreboard bench for irq_dispatch_seq: a small regfile/IE/IF environment
// plus a reference model that predicts every regfile write, bus write and IRQ clear.
module tb_irq_dispatch_seq;

    localparam logic [2:0] SEL_SP = 3'd3;
    localparam logic [2:0] SEL_PC = 3'd4;
    localparam logic [1:0] K_RR = 2'd0, K_MEM = 2'd1, K_IRQ = 2'd2, K_HX = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] d;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst, m_tick, ime, halted, instr_bound;
    logic [4:0]  ie_flags, if_flags;
    logic [15:0] rr_rdata;
    logic        read_rr, write_rr, mem_we, ime_clr, halt_exit, busy;
    logic [2:0]  read_reg_rr, write_reg_rr;
    logic [15:0] data_in_rr, mem_addr;
    logic [7:0]  mem_wdata;
    logic [4:0]  if_clr;

    logic [15:0] pc_reg, sp_reg;
    evt_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_ticks = 0;

    irq_dispatch_seq dut (
        .clk(clk), .rst(rst), .m_tick(m_tick), .ie_flags(ie_flags), .if_flags(if_flags),
        .ime(ime), .halted(halted), .instr_bound(instr_bound), .rr_rdata(rr_rdata),
        .read_rr(read_rr), .read_reg_rr(read_reg_rr), .write_rr(write_rr),
        .write_reg_rr(write_reg_rr), .data_in_rr(data_in_rr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .if_clr(if_clr), .ime_clr(ime_clr),
        .halt_exit(halt_exit), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rr_rdata = (read_reg_rr == SEL_PC) ? pc_reg :
                      (read_reg_rr == SEL_SP) ? sp_reg : 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        evt_t e;
        e.kind = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic match_evt(input string name, input logic [1:0] k,
                             input logic [15:0] a, input logic [15:0] d);
        evt_t act;
        evt_t e;
        act.kind = k; act.a = a; act.d = d;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event %h, none expected", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, 64'(act), 64'(e));
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (halt_exit) match_evt("halt_exit", K_HX, 16'h0000, 16'h0000);
        if (write_rr) match_evt("rr_write", K_RR, {13'd0, write_reg_rr}, data_in_rr);
        if (mem_we) match_evt("mem_write", K_MEM, mem_addr, {8'd0, mem_wdata});
        if (if_clr != 5'd0 || ime_clr) match_evt("irq_clear", K_IRQ, {11'd0, if_clr}, {15'd0, ime_clr});
        if (!m_tick && (write_rr || mem_we || read_rr || ime_clr || halt_exit || if_clr != 5'd0)) begin
            checks++;
            errors++;
            $display("FAIL strobe_without_tick: strobes asserted with m_tick=0");
        end
    end

    // One clk of the environment: regfile, IE/IF registers, IME and HALT react to strobes.
    task automatic clk_step(input logic t);
        logic        c_wr, c_we, c_ime, c_hx;
        logic [2:0]  c_sel;
        logic [15:0] c_din, c_addr;
        logic [7:0]  c_wd;
        logic [4:0]  c_clr;
        m_tick = t;
        @(negedge clk);
        c_wr = write_rr; c_sel = write_reg_rr; c_din = data_in_rr;
        c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;
        c_clr = if_clr; c_ime = ime_clr; c_hx = halt_exit;
        if (t && busy) busy_ticks++;
        @(posedge clk);
        #1;
        if (c_wr && c_sel == SEL_PC) pc_reg = c_din;
        if (c_wr && c_sel == SEL_SP) sp_reg = c_din;
        if (c_we && c_addr == 16'hFFFF) ie_flags = c_wd[4:0];
        if (c_we && c_addr == 16'hFF0F) if_flags = c_wd[4:0];
        if_flags = if_flags & ~c_clr;
        if (c_ime) ime = 1'b0;
        if (c_hx) halted = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic mtick();
        repeat ($urandom_range(0, 2)) clk_step(1'b0);
        clk_step(1'b1);
    endtask

    // Reference model: the whole dispatch predicted from the architectural rules.
    task automatic dispatch(input string name, input logic [15:0] pc, input logic [15:0] sp,
                            input logic [4:0] ie, input logic [4:0] ifv,
                            input logic [4:0] extra, input logic hlt);
        logic [15:0] pc1, sp1, sp2, vec;
        logic [4:0]  ie4, pend4, clr;
        pc1 = pc - 16'd1;
        sp1 = sp - 16'd1;
        sp2 = sp1 - 16'd1;
        ie4 = (sp1 == 16'hFFFF) ? pc1[12:8] : ie;
        pend4 = ie4 & (ifv | extra);
        clr = 5'd0;
        vec = 16'h0000;
        for (int i = 4; i >= 0; i--) begin
            if (pend4[i]) begin
                clr = 5'd1 << i;
                vec = 16'h0040 + 16'(8 * i);
            end
        end
        if (hlt) push_evt(K_HX, 16'h0000, 16'h0000);
        push_evt(K_RR, {13'd0, SEL_PC}, pc1);
        push_evt(K_RR, {13'd0, SEL_SP}, sp1);
        push_evt(K_RR, {13'd0, SEL_SP}, sp2);
        push_evt(K_MEM, sp1, {8'd0, pc1[15:8]});
        push_evt(K_MEM, sp2, {8'd0, pc1[7:0]});
        push_evt(K_IRQ, {11'd0, clr}, 16'd1);
        push_evt(K_RR, {13'd0, SEL_PC}, vec);
        pc_reg = pc; sp_reg = sp; ie_flags = ie; if_flags = ifv;
        ime = 1'b1; halted = hlt; instr_bound = ~hlt;
        busy_ticks = 0;
        mtick();
        instr_bound = 1'b0;
        mtick();
        if_flags = if_flags | extra;
        repeat (4) mtick();
        check({name, "_busy_mcycles"}, 64'(busy_ticks), 64'd5);
        @(negedge clk);
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_final_pc_sp"}, {32'd0, pc_reg, sp_reg}, {32'd0, vec, sp2});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rpc, rsp;
        logic [4:0]  rie, rif;
        rst = 1'b1; m_tick = 1'b0; ime = 1'b0; halted = 1'b0; instr_bound = 1'b0;
        ie_flags = 5'd0; if_flags = 5'd0; pc_reg = 16'h0000; sp_reg = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_strobes", {58'd0, read_rr, write_rr, mem_we, ime_clr, halt_exit, busy}, 64'd0);
        check("reset_data", {16'd0, data_in_rr, mem_addr, mem_wdata, 3'd0, if_clr}, 64'd0);
        check("reset_selects", {58'd0, read_reg_rr, write_reg_rr}, {58'd0, SEL_PC, SEL_PC});
        @(posedge clk);
        #1;
        rst = 1'b0;
        clk_step(1'b0);

        dispatch("t1_basic", 16'h0150, 16'hFFFE, 5'h01, 5'h01, 5'h00, 1'b0);
        dispatch("t2_prio", 16'h1234, 16'hD000, 5'h14, 5'h14, 5'h00, 1'b0);
        check("t2_if_left", 64'(if_flags), 64'h10);
        dispatch("t2_second", 16'h0050, 16'hCFFE, 5'h14, if_flags, 5'h00, 1'b0);
        dispatch("t3_ie_overwrite", 16'h2001, 16'h0000, 5'h01, 5'h01, 5'h00, 1'b0);
        dispatch("t4_sp_wrap", 16'h0150, 16'h0000, 5'h01, 5'h01, 5'h00, 1'b0);
        dispatch("if_set_mid", 16'h4000, 16'hC100, 5'h1F, 5'h10, 5'h02, 1'b0);

        // HALT wake with IME clear: only the halt_exit pulse, no dispatch.
        ime = 1'b0; halted = 1'b1; instr_bound = 1'b0; ie_flags = 5'h02; if_flags = 5'h02;
        push_evt(K_HX, 16'h0000, 16'h0000);
        busy_ticks = 0;
        repeat (3) mtick();
        check("t5_no_busy", 64'(busy_ticks), 64'd0);
        check("t5_halt_cleared", 64'(halted), 64'd0);

        // Reset in M3: only the M1/M2 writes happen, then a clean dispatch from PC=0000.
        pc_reg = 16'h0300; sp_reg = 16'hC800; ie_flags = 5'h04; if_flags = 5'h04;
        ime = 1'b1; instr_bound = 1'b1;
        push_evt(K_RR, {13'd0, SEL_PC}, 16'h02FF);
        push_evt(K_RR, {13'd0, SEL_SP}, 16'hC7FF);
        mtick();
        instr_bound = 1'b0;
        mtick();
        mtick();
        rst = 1'b1;
        clk_step(1'b0);
        @(negedge clk);
        check("t6_rst_idle", {61'd0, busy, mem_we, write_rr}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dispatch("t6_after_rst", 16'h0000, 16'hFFFE, 5'h04, 5'h04, 5'h00, 1'b0);

        for (int k = 0; k < 16; k++) begin
            rpc = 16'($urandom);
            rsp = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
            do begin
                rie = 5'($urandom);
                rif = 5'($urandom);
            end while ((rie & rif) == 5'd0);
            dispatch("rand", rpc, rsp, rie, rif, 5'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (4) clk_step(1'b0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
